// File: rtl/dlog_search.sv
// Brute-force discrete-log search: smallest x in [0, max_exp] with g^x mod r == y.
// Optional early stop at the order of g when DLOG_ORDER_DETECT_EN is defined.
module dlog_search #(
  parameter int unsigned len = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [len-1:0] g_in,
  input  logic [len-1:0] y_in,
  input  logic [len-1:0] r,
  input  logic [len-1:0] max_exp,
  output logic [len-1:0] x_out,
  output logic           found,
  output logic           done,
  output logic           busy
);

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StCompare,
    StMul,
    StMulWait,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [len-1:0] acc_q, acc_d;
  logic [len-1:0] x_q, x_d;
  logic [len-1:0] g_q, g_d;
  logic [len-1:0] y_q, y_d;
  logic [len-1:0] lim_q, lim_d;
  logic [len-1:0] mul_a_q, mul_a_d;
  logic [len-1:0] mul_b_q, mul_b_d;
  logic [len-1:0] x_out_q, x_out_d;
  logic           found_q, found_d;
  logic           done_q, done_d;

  // Combinational modular multiply on registered operands; r is held stable while busy.
  logic [2*len-1:0] prod;
  logic [2*len-1:0] r_ext;
  logic [len-1:0]   mul_c;

  always_comb begin
    prod  = mul_a_q * mul_b_q;
    r_ext = {{len{1'b0}}, r};
    mul_c = '0;
    if (r != '0) begin
      mul_c = len'(prod % r_ext);
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    x_d     = x_q;
    g_d     = g_q;
    y_d     = y_q;
    lim_d   = lim_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    x_out_d = x_out_q;
    found_d = found_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StInit;
        end
      end
      StInit: begin
        g_d     = g_in;
        y_d     = y_in;
        lim_d   = max_exp;
        acc_d   = len'(1);
        x_d     = '0;
        found_d = 1'b0;
        x_out_d = '0;
        // A modulus below 2 has no meaningful residues; report not found at once.
        if (r < len'(2)) begin
          state_d = StDone;
        end else begin
          state_d = StCompare;
        end
      end
      StCompare: begin
        if (acc_q == y_q) begin
          found_d = 1'b1;
          x_out_d = x_q;
          state_d = StDone;
`ifdef DLOG_ORDER_DETECT_EN
        end else if ((x_q != '0) && (acc_q == len'(1))) begin
          // Powers of g have cycled back to 1: no new residue can appear.
          x_out_d = x_q;
          state_d = StDone;
`endif
        end else if (x_q == lim_q) begin
          x_out_d = x_q;
          state_d = StDone;
        end else begin
          state_d = StMul;
        end
      end
      StMul: begin
        mul_a_d = acc_q;
        mul_b_d = g_q;
        state_d = StMulWait;
      end
      StMulWait: begin
        // Bound check precedes this increment, so x never wraps.
        acc_d   = mul_c;
        x_d     = x_q + len'(1);
        state_d = StCompare;
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      x_q     <= '0;
      g_q     <= '0;
      y_q     <= '0;
      lim_q   <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      x_out_q <= '0;
      found_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      g_q     <= g_d;
      y_q     <= y_d;
      lim_q   <= lim_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      x_out_q <= x_out_d;
      found_q <= found_d;
      done_q  <= done_d;
    end
  end

  assign x_out = x_out_q;
  assign found = found_q;
  assign done  = done_q;
  assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_dlog_search.sv
// Bench for dlog_search: random and directed searches checked every cycle
// against an arithmetic model of the search result and its latency.
module tb_dlog_search;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] g_in = '0;
  logic [15:0] y_in = '0;
  logic [15:0] r = '0;
  logic [15:0] max_exp = '0;
  logic [15:0] x_out;
  logic        found;
  logic        done;
  logic        busy;

  dlog_search #(.len(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .g_in   (g_in),
    .y_in   (y_in),
    .r      (r),
    .max_exp(max_exp),
    .x_out  (x_out),
    .found  (found),
    .done   (done),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Result model: walk powers of g directly; latency is 3 edges per exponent plus 4.
  task automatic model(input int g, input int y, input int rr, input int lim,
                       output int f, output int k, output int lat);
    longint acc;
    f = 0;
    k = 0;
    lat = 3;
    if (rr < 2) return;
    acc = 1;
    for (int x = 0; x <= lim; x++) begin
      k = x;
      if (acc == longint'(y)) begin
        f = 1;
        break;
      end
`ifdef DLOG_ORDER_DETECT_EN
      if (x != 0 && acc == 1) break;
`endif
      if (x == lim) break;
      acc = (acc * longint'(g)) % longint'(rr);
    end
    lat = 3 * k + 4;
  endtask

  // Per-cycle checker; n_cur counts edges since the one that sampled start.
  bit chk_en = 1'b0;
  int n_cur = 0;
  int exp_f = 0;
  int exp_k = 0;
  int exp_lat = 0;

  always @(posedge clk) begin
    if (!chk_en) n_cur <= 0;
    else         n_cur <= n_cur + 1;
  end

  always @(negedge clk) begin
    if (chk_en && n_cur >= 1) begin
      chk("busy", busy, (n_cur < exp_lat) ? 1 : 0);
      chk("done", done, (n_cur == exp_lat) ? 1 : 0);
      if (n_cur >= exp_lat - 1) begin
        chk("found", found, exp_f);
        chk("x_out", x_out, exp_k);
      end else if (n_cur >= 2) begin
        chk("found_cleared", found, 0);
        chk("x_out_cleared", x_out, 0);
      end
    end
  end

  // poke > 0 raises start for the edge after edge 'poke' (must land in a busy state).
  task automatic run(input int g, input int y, input int rr, input int lim, input int poke);
    int f, k, lat;
    model(g, y, rr, lim, f, k, lat);
    @(negedge clk);
    exp_f   = f;
    exp_k   = k;
    exp_lat = lat;
    g_in    = 16'(g);
    y_in    = 16'(y);
    r       = 16'(rr);
    max_exp = 16'(lim);
    start   = 1'b1;
    chk_en  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    while (n_cur < exp_lat + 2) begin
      @(negedge clk);
      start = (poke > 0 && n_cur == poke) ? 1'b1 : 1'b0;
    end
    start  = 1'b0;
    chk_en = 1'b0;
    @(negedge clk);
  endtask

  task automatic pin(input string name, input int g, input int y, input int rr, input int lim,
                     input int ef, input int ek, input int elat);
    int f, k, lat;
    model(g, y, rr, lim, f, k, lat);
    chk({name, "_found"}, f, ef);
    chk({name, "_x"}, k, ek);
    chk({name, "_lat"}, lat, elat);
  endtask

  initial begin
    #2 rst = 1'b0;
    #1;
    chk("rst_x_out", x_out, 0);
    chk("rst_found", found, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    #20 rst = 1'b1;

    pin("a", 5, 8, 23, 20, 1, 6, 22);
    pin("b", 5, 1, 23, 20, 1, 0, 4);
    pin("c", 5, 8, 23, 5, 0, 5, 19);
`ifdef DLOG_ORDER_DETECT_EN
    pin("d", 2, 5, 23, 20, 0, 11, 37);
`else
    pin("d", 2, 5, 23, 20, 0, 20, 64);
`endif
    pin("e", 7, 3, 1, 20, 0, 0, 3);
    pin("f", 7, 3, 0, 20, 0, 0, 3);

    run(5, 8, 23, 20, 0);
    run(5, 1, 23, 20, 0);
    run(5, 8, 23, 5, 0);
    run(2, 5, 23, 20, 0);
    run(7, 3, 1, 20, 0);
    run(7, 3, 0, 20, 0);
    run(5, 8, 23, 0, 0);
    run(5, 8, 23, 20, 4);
    run(5, 8, 23, 20, 21);

    // Asynchronous reset mid-search.
    @(negedge clk);
    g_in = 16'd5; y_in = 16'd8; r = 16'd23; max_exp = 16'd20;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_found", found, 0);
    chk("abort_x_out", x_out, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (30) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
      chk("abort_idle", busy, 0);
    end
    run(5, 8, 23, 20, 0);

    for (int i = 0; i < 30; i++) begin
      int rr, g, y, lim, k0;
      longint acc;
      rr  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 250));
      g   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 250));
      lim = $urandom_range(0, 40);
      if ($urandom_range(0, 1) == 0 && rr >= 2) begin
        k0  = $urandom_range(0, 45);
        acc = 1;
        for (int j = 0; j < k0; j++) acc = (acc * longint'(g)) % longint'(rr);
        y = int'(acc);
      end else begin
        y = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 250));
      end
      run(g, y, rr, lim, ($urandom_range(0, 4) == 0) ? 2 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dlog_search.md
Name: dlog_search

Overview:
- Brute-force discrete-logarithm solver; the inverse direction of the modular-exponentiation engine.
- Given generator g, target y and modulus r, finds the smallest x in [0, max_exp] with g^x mod r == y.
- Used by the discrete-log-hardness demonstration and test harness to recover small Schnorr secrets and nonces.
- Uses one combinational mod_mul instance (ports a, b, r, c) with a registered-operand, two-state multiply, so iteration timing is deterministic.

Parameters:
- len, 16, datapath width of g, y, r, max_exp and x_out. Supplied by the shared parameter include.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset (asserted when 0)
- start  input  1  begin search; sampled only in IDLE
- g_in  input  len  generator (base)
- y_in  input  len  target value
- r  input  len  modulus; must be held stable while busy
- max_exp  input  len  inclusive exponent search bound
- x_out  output  len  exponent found, or last exponent tested
- found  output  1  1 = x_out satisfies g^x_out mod r == y
- done  output  1  one-cycle completion pulse
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, rst=0): state=IDLE; x_out=0, found=0, done=0, busy=0; internal acc, x, g, y cleared.
- Reset mid-search aborts immediately. No done pulse is produced.
- States: IDLE, INIT, COMPARE, MUL, MUL_WAIT, DONE.
- IDLE: done<=0. If start, go to INIT. start is ignored in every other state.
- INIT:
  - Latch g<=g_in, y<=y_in, lim<=max_exp; acc<=1, x<=0; found<=0, x_out<=0.
  - If r<2, go to DONE (found stays 0, x_out=0). Otherwise go to COMPARE.
- COMPARE, checked in priority order:
  - acc==y: found<=1, x_out<=x, go to DONE.
  - x==lim: x_out<=x, go to DONE (found=0).
  - Otherwise go to MUL.
- MUL: mul_a<=acc, mul_b<=g; go to MUL_WAIT.
- MUL_WAIT: acc<=mul_c, x<=x+1; go to COMPARE.
- DONE: done<=1 for exactly one cycle; go to IDLE. x_out and found hold until the next INIT.
- Arithmetic:
  - acc is always < r after the first multiply. The initial acc=1 is valid because r>=2.
  - y_in>=r never matches unless y_in==1 (x=0). No error is flagged; the search runs to the bound.
  - g_in is not pre-reduced; mod_mul reduces the product.
  - g_in=0 gives acc=0 from x=1 onward.
- Counter x never wraps: the search stops at x==lim before any increment. max_exp=2^len-1 is therefore legal.
- Latency: count the edge that samples start as edge 1. For a result at exponent k (match or bound), done is high after edge 3k+4. The r<2 case gives done after edge 3.
- busy is asserted from the edge after start is sampled until the edge that returns to IDLE.

Optional Feature:
- Macro: DLOG_ORDER_DETECT_EN.
- When defined: in COMPARE, after the match check fails and before the bound check, if x!=0 and acc==1, then x_out<=x, found<=0, go to DONE. This stops at the order of g, since no new residues can follow.
- When undefined: no early stop; the search always runs to a match or to max_exp.

Test Plan:
- r=23, g=5, y=8, max_exp=20 -> found=1, x_out=6; done high after edge 22; done exactly one cycle; busy low afterwards.
- r=23, g=5, y=1, max_exp=20 -> found=1, x_out=0; done after edge 4.
- r=23, g=5, y=8, max_exp=5 -> found=0, x_out=5; done after edge 19.
- r=23, g=2, y=5 (5 is not in the subgroup of 2), max_exp=20:
  - With DLOG_ORDER_DETECT_EN: found=0, x_out=11, done after edge 37.
  - Without it: found=0, x_out=20, done after edge 64.
- r=1, any g, y -> found=0, x_out=0, done after edge 3. Repeat with r=0: same result.
- Start the r=23, g=5, y=8 search, pulse rst=0 asynchronously at edge 10: all outputs go to 0 immediately with no done. Then:
  - Pulse start during busy: ignored.
  - Re-run after reset: returns x_out=6.
